// File: rtl/user_proj_yblock_if.sv
// Wishbone slave bus of the Caravel user-project wrapper; the yblock ties it off.
// Latency: none (the bus is never acknowledged). Backpressure: none, ack is held low.
interface user_proj_yblock_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/user_proj_yblock.sv
// 16x16 Morphle-style cell array, configured through 16 per-column shift chains off LA pins.
// Latency: config shifts one bit per confclk edge; the data path is purely combinational.
// Backpressure: none; Wishbone and IO are tied off.
module user_proj_yblock (
    input  logic         vdda1,
    input  logic         vdda2,
    input  logic         vssa1,
    input  logic         vssa2,
    input  logic         vccd1,
    input  logic         vccd2,
    input  logic         vssd1,
    input  logic         vssd2,
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    user_proj_yblock_if.slave wbs,
    input  logic [127:0] la_data_in,
    output logic [127:0] la_data_out,
    input  logic [127:0] la_oen,
    input  logic [37:0]  io_in,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb
);
    logic        clk;
    logic        rst;
    logic [15:0] cbitin;
    logic [15:0] us;
    logic [15:0] ub;
    logic [15:0] ds;
    logic [15:0] db;
    logic [15:0] cbitout;
    logic        unused_inputs;

    // Column chain: row r occupies bits [3r+2:3r], so a plain left shift
    // carries cfg[r-1][2] into cfg[r][0] and bit 47 is the row-15 MSB.
    logic [47:0] col_chain [16];

    assign clk    = la_data_in[112];
    assign rst    = la_data_in[113];
    assign cbitin = la_data_in[111:96];
    assign ub     = la_data_in[95:80];
    assign us     = la_data_in[79:64];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (rst) begin
                col_chain[i] <= '0;
            end else begin
                col_chain[i] <= {col_chain[i][46:0], cbitin[i]};
            end
        end
    end

    always_comb begin
        cbitout = '0;
        for (int i = 0; i < 16; i++) begin
            cbitout[i] = col_chain[i][47];
        end
    end

    // Returns {vo_s, vo_b, ho_s, ho_b}; every b is masked by its s.
    function automatic logic [3:0] cell_eval(
        input logic [2:0] code,
        input logic       h_s,
        input logic       h_b,
        input logic       v_s,
        input logic       v_b
    );
        logic vo_s;
        logic vo_b;
        logic ho_s;
        logic ho_b;
        vo_s = 1'b0;
        vo_b = 1'b0;
        ho_s = 1'b0;
        ho_b = 1'b0;
        case (code)
            3'd1: begin vo_s = v_s; vo_b = v_b; ho_s = h_s; ho_b = h_b; end
            3'd2: begin ho_s = h_s; ho_b = h_b; end
            3'd3: begin vo_s = v_s; vo_b = v_b; end
            3'd4: begin vo_s = v_s; vo_b = v_b; ho_s = h_s & v_s; ho_b = h_b & v_b;  end
            3'd5: begin vo_s = v_s; vo_b = v_b; ho_s = h_s & v_s; ho_b = h_b & ~v_b; end
            3'd6: begin vo_s = h_s; vo_b = h_b; end
            default: ;
        endcase
        return {vo_s, vo_b & vo_s, ho_s, ho_b & ho_s};
    endfunction

    always_comb begin : eval_array
        logic [15:0] v_s;
        logic [15:0] v_b;
        logic        h_s;
        logic        h_b;
        logic [3:0]  res;
        v_s = us;
        v_b = ub;
        h_s = 1'b1;
        h_b = 1'b1;
        res = '0;
        for (int r = 0; r < 16; r++) begin
            h_s = 1'b1;
            h_b = 1'b1;
            for (int i = 0; i < 16; i++) begin
                res    = cell_eval(col_chain[i][3*r +: 3], h_s, h_b, v_s[i], v_b[i]);
                v_s[i] = res[3];
                v_b[i] = res[2];
                h_s    = res[1];
                h_b    = res[0];
            end
        end
        ds = v_s;
        db = v_b;
    end

    assign la_data_out   = {80'b0, cbitout, db, ds};
    assign io_out        = '0;
    assign io_oeb        = '1;
    assign wbs.wbs_ack_o = 1'b0;
    assign wbs.wbs_dat_o = '0;

    assign unused_inputs = ^{vdda1, vdda2, vssa1, vssa2, vccd1, vccd2, vssd1, vssd2,
                             wb_clk_i, wb_rst_i, wbs.wbs_stb_i, wbs.wbs_cyc_i, wbs.wbs_we_i,
                             wbs.wbs_sel_i, wbs.wbs_dat_i, wbs.wbs_adr_i,
                             la_data_in[127:114], la_data_in[63:0], la_oen, io_in};
endmodule

// File: tb/tb_user_proj_yblock.sv
// Directed and randomized bench for user_proj_yblock against a shift-history/signal-pair model.
module tb_user_proj_yblock;
    typedef struct {
        logic s;
        logic b;
    } sig_t;

    logic         confclk = 1'b0;
    logic         rst     = 1'b0;
    logic         wb_clk  = 1'b0;
    logic         wb_rst  = 1'b0;
    logic [15:0]  cbitin  = '0;
    logic [15:0]  us      = '0;
    logic [15:0]  ub      = '0;
    logic [63:0]  junk    = '0;
    logic [127:0] la_data_in;
    logic [127:0] la_data_out;
    logic [127:0] la_oen  = '0;
    logic [37:0]  io_in   = '0;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;

    int tests = 0;
    int fails = 0;

    logic [2:0] want [16][16];
    bit         hist [16][$];

    user_proj_yblock_if wbs_bus ();

    assign la_data_in = {14'h0, rst, confclk, cbitin, ub, us, junk};

    user_proj_yblock dut (
        .vdda1      (1'b1),
        .vdda2      (1'b1),
        .vssa1      (1'b0),
        .vssa2      (1'b0),
        .vccd1      (1'b1),
        .vccd2      (1'b1),
        .vssd1      (1'b0),
        .vssd2      (1'b0),
        .wb_clk_i   (wb_clk),
        .wb_rst_i   (wb_rst),
        .wbs        (wbs_bus.slave),
        .la_data_in (la_data_in),
        .la_data_out(la_data_out),
        .la_oen     (la_oen),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb)
    );

    always #7 wb_clk = ~wb_clk;

    // Row r, bit k of a column holds the bit shifted in 3r+k+1 edges ago.
    function automatic logic [2:0] m_code(int r, int i);
        logic [2:0] c;
        c = '0;
        for (int k = 0; k < 3; k++) begin
            if (3*r + k < hist[i].size()) c[k] = hist[i][3*r + k];
        end
        return c;
    endfunction

    function automatic logic [127:0] model_out();
        sig_t        v [16];
        sig_t        h;
        sig_t        nv;
        sig_t        empty;
        logic [2:0]  c;
        logic [15:0] m_ds;
        logic [15:0] m_db;
        logic [15:0] m_cbo;
        empty = '{s: 1'b0, b: 1'b0};
        for (int i = 0; i < 16; i++) v[i] = '{s: us[i], b: us[i] & ub[i]};
        for (int r = 0; r < 16; r++) begin
            h = '{s: 1'b1, b: 1'b1};
            for (int i = 0; i < 16; i++) begin
                c  = m_code(r, i);
                nv = empty;
                case (c)
                    3'd1: nv = v[i];
                    3'd2: nv = empty;
                    3'd3: begin nv = v[i]; h = empty; end
                    3'd4: begin nv = v[i]; h.s = h.s & v[i].s; h.b = h.s & h.b & v[i].b;  end
                    3'd5: begin nv = v[i]; h.s = h.s & v[i].s; h.b = h.s & h.b & ~v[i].b; end
                    3'd6: begin nv = h; h = empty; end
                    default: begin nv = empty; h = empty; end
                endcase
                v[i] = nv;
            end
        end
        for (int i = 0; i < 16; i++) begin
            m_ds[i]  = v[i].s;
            m_db[i]  = v[i].b;
            m_cbo[i] = (hist[i].size() > 47) ? hist[i][47] : 1'b0;
        end
        return {80'b0, m_cbo, m_db, m_ds};
    endfunction

    task automatic model_clock();
        for (int i = 0; i < 16; i++) begin
            if (rst) begin
                hist[i].delete();
            end else begin
                hist[i].push_front(cbitin[i]);
                if (hist[i].size() > 48) void'(hist[i].pop_back());
            end
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic conf_tick();
        #1 confclk = 1'b1;
        model_clock();
        #4 confclk = 1'b0;
        #5;
    endtask

    // The first bit shifted ends up deepest, so rows are fed 15 down to 0, MSB first.
    task automatic load_want();
        for (int t = 0; t < 48; t++) begin
            for (int i = 0; i < 16; i++) cbitin[i] = want[15 - t/3][i][2 - t%3];
            conf_tick();
            check("load_step", la_data_out, model_out());
        end
        cbitin = '0;
    endtask

    task automatic fill_want(input logic [2:0] code);
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < 16; i++) want[r][i] = code;
    endtask

    initial begin
        wbs_bus.wbs_stb_i = 1'b0;
        wbs_bus.wbs_cyc_i = 1'b0;
        wbs_bus.wbs_we_i  = 1'b0;
        wbs_bus.wbs_sel_i = '0;
        wbs_bus.wbs_dat_i = '0;
        wbs_bus.wbs_adr_i = '0;
        junk  = {$urandom, $urandom};
        io_in = {6'h0, $urandom};
        la_oen = {$urandom, $urandom, $urandom, $urandom};

        // Reset with the top edge fully driven
        rst = 1'b1; us = 16'hFFFF; ub = 16'hFFFF;
        conf_tick();
        conf_tick();
        rst = 1'b0;
        #1;
        check("reset_out", la_data_out, 128'h0);
        check("reset_model", la_data_out, model_out());
        check("wbs_ack", {127'b0, wbs_bus.wbs_ack_o}, 128'h0);
        check("wbs_dat", {96'b0, wbs_bus.wbs_dat_o}, 128'h0);
        check("io_out", {90'b0, io_out}, 128'h0);
        check("io_oeb", {90'b0, io_oeb}, {90'b0, {38{1'b1}}});

        // Column 0 filled with ones: every cell becomes code 7
        cbitin = 16'h0001;
        for (int n = 1; n <= 48; n++) begin
            conf_tick();
            check("shift_c0", la_data_out, model_out());
            if (n == 47) check("c0_cbitout_47", {127'b0, la_data_out[32]}, 128'h0);
        end
        cbitin = '0;
        check("c0_full", la_data_out, {80'b0, 16'h0001, 32'h0});

        // Pass-through arrays
        fill_want(3'd1);
        load_want();
        us = 16'hFFFF; ub = 16'h00AA; #1;
        check("pass_001", la_data_out, {80'b0, 16'h0000, 16'h00AA, 16'hFFFF});
        fill_want(3'd3);
        load_want();
        #1;
        check("pass_bar", la_data_out, {80'b0, 16'h0000, 16'h00AA, 16'hFFFF});

        // Match at column 0 row 15, routed right and turned down at column 5
        fill_want(3'd0);
        for (int r = 0; r < 15; r++) want[r][0] = 3'd3;
        want[15][0] = 3'd4;
        for (int i = 1; i < 16; i++) want[15][i] = 3'd2;
        want[15][5] = 3'd6;
        load_want();
        us = 16'h0001; ub = 16'h0001; #1;
        check("route_ds5_hit", {127'b0, la_data_out[5]}, 128'h1);
        check("route_db5_hit", {127'b0, la_data_out[21]}, 128'h1);
        check("route_full_hit", la_data_out, {80'b0, 16'h0021, 16'h0021, 16'h0021});
        ub = 16'h0000; #1;
        check("route_ds5_miss", {127'b0, la_data_out[5]}, 128'h1);
        check("route_db5_miss", {127'b0, la_data_out[21]}, 128'h0);
        check("route_model_miss", la_data_out, model_out());
        us = 16'h0000; #1;
        check("route_ds5_empty", {127'b0, la_data_out[5]}, 128'h0);
        check("route_model_empty", la_data_out, model_out());

        // Random configurations and top-edge patterns
        for (int n = 0; n < 6; n++) begin
            for (int r = 0; r < 16; r++)
                for (int i = 0; i < 16; i++) want[r][i] = 3'($urandom_range(0, 7));
            load_want();
            for (int p = 0; p < 4; p++) begin
                us = 16'($urandom); ub = 16'($urandom); junk = {$urandom, $urandom};
                #1;
                check("rand_pattern", la_data_out, model_out());
            end
        end

        // Reset in the middle of a load
        us = 16'hFFFF; ub = 16'h5A5A;
        for (int n = 0; n < 20; n++) begin
            cbitin = 16'($urandom) | 16'h8001;
            conf_tick();
        end
        rst = 1'b1; cbitin = 16'hFFFF;
        conf_tick();
        check("midload_reset", la_data_out, 128'h0);
        check("midload_model", la_data_out, model_out());
        rst = 1'b0; cbitin = '0;

        // Wishbone activity and an unknown wb_rst_i must not disturb the array
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < 16; i++) want[r][i] = 3'($urandom_range(1, 6));
        load_want();
        us = 16'($urandom); ub = 16'($urandom);
        wb_rst = 1'bx;
        for (int n = 0; n < 5; n++) begin
            wbs_bus.wbs_stb_i = 1'($urandom);
            wbs_bus.wbs_cyc_i = 1'($urandom);
            wbs_bus.wbs_we_i  = 1'($urandom);
            wbs_bus.wbs_sel_i = 4'($urandom);
            wbs_bus.wbs_dat_i = $urandom;
            wbs_bus.wbs_adr_i = $urandom;
            #50;
            check("wb_isolation", la_data_out, model_out());
            check("wb_ack_idle", {96'b0, wbs_bus.wbs_dat_o, wbs_bus.wbs_ack_o}, 128'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
